apu_request_queue: RTL and testbench
====================================

# apu_request_queue

Elastic buffer between the core's APU request port and `vector_decoder`. It accepts instruction packets (instruction word, two scalar operands, op, flags) from the core whenever space is available. It presents them to the decoder in order using a req/gnt handshake, and tracks how many issued instructions have not yet returned `apu_rvalid`. This decouples core issue from multi-cycle vector execution, so the core stalls only when the queue is full.

## Interface
Parameters:
- `DEPTH`, 4: number of queue entries; power of two, ≥ 2.
- `MAX_OUTSTANDING`, 1: maximum number of instructions issued to the decoder without a returned `dec_rvalid`; ≥ 1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `flush` input 1: synchronous clear of queued, not-yet-issued entries.
- `core_req` input 1: core presents a request.
- `core_gnt` output 1: queue accepts the request this cycle.
- `core_operands` input 3×32: [0] instruction word, [1]/[2] scalar operands.
- `core_op` input 6: APU op field.
- `core_flags` input 15: APU flags.
- `dec_req` output 1: head entry valid towards the decoder.
- `dec_gnt` input 1: decoder accepts the head entry.
- `dec_operands` output 3×32: head entry operands.
- `dec_op` output 6: head entry op.
- `dec_flags` output 15: head entry flags.
- `dec_rvalid` input 1: decoder completion strobe.
- `count` output $clog2(DEPTH+1): number of occupied entries.
- `outstanding` output $clog2(MAX_OUTSTANDING+1): number of issued, uncompleted instructions.
- `full` output 1: `count == DEPTH`.
- `empty` output 1: `count == 0`.

## Operation
- **Push** when `core_req & core_gnt`. The packet is written at the write pointer, and the write pointer increments modulo `DEPTH`.
- `core_gnt = ~full & ~flush & ~reset`. There is no pass-through when full: a simultaneous pop does not free a slot in the same cycle.
- **Pop** when `dec_req & dec_gnt`. The read pointer increments modulo `DEPTH`.
- `dec_req = ~empty & ~flush & ~reset & (outstanding < MAX_OUTSTANDING)`.
- `dec_*` data outputs always show the entry at the read pointer, even when `dec_req` is low.
- `count` update per cycle: +1 on push only, −1 on pop only, unchanged on both.
- `outstanding` update per cycle: +1 on pop only, −1 on `dec_rvalid` only, unchanged on both.
- A `dec_rvalid` when `outstanding == 0` is ignored (no underflow) and flagged by a simulation assertion.
- **Flush**: at the next edge, pointers and `count` return to 0. `outstanding` is not affected; in-flight instructions still complete. No push or pop occurs during a flush cycle.
- **Reset**: all of the following are cleared asynchronously:
  - pointers, `count` and `outstanding` return to 0;
  - storage returns to 0;
  - `core_gnt = 0`, `dec_req = 0`, `dec_*` data = 0, `full = 0`, `empty = 1`.
- An active reset mid-transfer discards all entries and in-flight tracking.

## Timing
- Without bypass, latency from push to earliest `dec_req` is 1 cycle (the entry is registered first).
- Sustained throughput is one push and one pop per cycle when `MAX_OUTSTANDING` permits.
- `dec_req`, once asserted, stays high with stable data until granted, flushed or reset.
- The decoder grants only in its WAIT state. With `MAX_OUTSTANDING = 1`, the next `dec_req` rises in the cycle after `dec_rvalid`, because the `outstanding` decrement is registered.

## Configuration
- Macro: `APU_QUEUE_BYPASS_EN`.
- **Defined**: when `empty` and the `outstanding` limit allows, `dec_req = core_req` and `dec_*` data are muxed combinationally from the `core_*` inputs.
  - If `dec_gnt` is also high, the packet is not written, `count` stays 0 and `outstanding` increments. This gives zero-cycle latency.
  - If `dec_gnt` is low, the packet is pushed normally.
- **Undefined**: registered path only, with a minimum latency of 1 cycle.

## Structure
- Shared package `accelerator_pkg` gains:
  - `apu_req_entry_t`, a packed struct `{logic [2:0][31:0] operands; logic [5:0] op; logic [14:0] flags;}` (117 bits);
  - constant `APU_QUEUE_DEPTH_DEFAULT = 4`.
- One sub-module, `apu_queue_storage`: a `DEPTH`×`apu_req_entry_t` register array with write port (`we`, `waddr`, `wdata`) and asynchronous read port (`raddr`, `rdata`).
- Pointers, counters, handshake and bypass logic stay in the top level.

## Test plan
- **Single request**: after reset, push op=6'h01 with instr=32'h0000_0057.
  - Without bypass: `dec_req` rises next cycle with matching data, `count` = 1→0 on grant.
  - With bypass: `dec_req` rises the same cycle.
- **Fill**: push 4 requests with `dec_gnt = 0` → `full = 1`, `core_gnt = 0`, `count = 4`; a 5th `core_req` is held off until a pop, and order is preserved on drain.
- **Outstanding limit**: `MAX_OUTSTANDING = 1`, two entries queued, `dec_gnt = 1`.
  - First pops, then `dec_req` stays low until `dec_rvalid`.
  - Second `dec_req` rises the cycle after `dec_rvalid`.
- **Simultaneous events**: push and pop in the same cycle at `count = 2` → `count` stays 2; `dec_rvalid` and a pop in the same cycle → `outstanding` unchanged.
- **Flush**: 3 entries queued, 1 outstanding, assert `flush` → `count = 0`, `empty = 1`, `outstanding = 1`; a later `dec_rvalid` brings `outstanding` to 0.
- **Reset and wrap**: assert `reset` mid-drain → all outputs reach their reset values immediately. Then push/pop 9 entries through `DEPTH = 4` to check pointer wrap-around and data integrity.

Source files
------------

// File: rtl/accelerator_pkg.sv
// Shared accelerator types: the APU request packet carried from the core to the vector decoder.
package accelerator_pkg;

  localparam int APU_QUEUE_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [2:0][31:0] operands;
    logic [5:0]       op;
    logic [14:0]      flags;
  } apu_req_entry_t;

endpackage

// File: rtl/apu_queue_storage.sv
// Entry storage for the APU request queue: register array, one write port, combinational read port.
module apu_queue_storage
  import accelerator_pkg::*;
#(
  parameter int DEPTH = APU_QUEUE_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  apu_req_entry_t           wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output apu_req_entry_t           rdata
);

  apu_req_entry_t mem [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apu_request_queue.sv
// In-order elastic queue between the core APU port and the vector decoder with outstanding tracking.
// Optional zero-latency bypass when empty: define APU_QUEUE_BYPASS_EN.
module apu_request_queue
  import accelerator_pkg::*;
#(
  parameter int DEPTH           = APU_QUEUE_DEPTH_DEFAULT,
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               core_req,
  output logic                               core_gnt,
  input  logic [2:0][31:0]                   core_operands,
  input  logic [5:0]                         core_op,
  input  logic [14:0]                        core_flags,
  output logic                               dec_req,
  input  logic                               dec_gnt,
  output logic [2:0][31:0]                   dec_operands,
  output logic [5:0]                         dec_op,
  output logic [14:0]                        dec_flags,
  input  logic                               dec_rvalid,
  output logic [$clog2(DEPTH+1)-1:0]         count,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                               full,
  output logic                               empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);

  logic [AW-1:0]  wptr_reg;
  logic [AW-1:0]  rptr_reg;
  logic [CW-1:0]  count_reg;
  logic [OW-1:0]  outstanding_reg;

  apu_req_entry_t core_entry;
  apu_req_entry_t head_entry;
  apu_req_entry_t rdata;
  logic           issue_ok;
  logic           bypass_take;
  logic           push;
  logic           pop;
  logic           issue;
  logic           rvalid_ok;

  assign core_entry.operands = core_operands;
  assign core_entry.op       = core_op;
  assign core_entry.flags    = core_flags;

  assign full     = (count_reg == DEPTH_C);
  assign empty    = (count_reg == '0);
  assign core_gnt = ~full & ~flush & ~reset;
  assign issue_ok = ~flush & ~reset & (outstanding_reg < MAX_OUT_C);

`ifdef APU_QUEUE_BYPASS_EN
  logic bypass_sel;

  // An empty queue forwards the core packet straight to the decoder.
  assign bypass_sel  = empty & issue_ok;
  assign dec_req     = bypass_sel ? core_req : (~empty & issue_ok);
  assign head_entry  = bypass_sel ? core_entry : rdata;
  assign bypass_take = bypass_sel & core_req & dec_gnt;
`else
  assign dec_req     = ~empty & issue_ok;
  assign head_entry  = rdata;
  assign bypass_take = 1'b0;
`endif

  assign push      = core_req & core_gnt & ~bypass_take;
  assign pop       = dec_req & dec_gnt & ~bypass_take;
  assign issue     = dec_req & dec_gnt;
  assign rvalid_ok = dec_rvalid & (outstanding_reg != '0);

  assign dec_operands = head_entry.operands;
  assign dec_op       = head_entry.op;
  assign dec_flags    = head_entry.flags;
  assign count        = count_reg;
  assign outstanding  = outstanding_reg;

  apu_queue_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wptr_reg),
    .wdata (core_entry),
    .raddr (rptr_reg),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) wptr_reg <= wptr_reg + AW'(1);
      if (pop)  rptr_reg <= rptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Flush leaves in-flight tracking alone: issued instructions still complete.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding_reg <= '0;
    end else begin
      case ({issue, rvalid_ok})
        2'b10:   outstanding_reg <= outstanding_reg + OW'(1);
        2'b01:   outstanding_reg <= outstanding_reg - OW'(1);
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  a_no_rvalid_underflow : assert property (@(posedge clk) disable iff (reset)
    !(dec_rvalid && (outstanding_reg == '0)));

endmodule

// File: tb/tb_apu_request_queue.sv
// Directed bench for apu_request_queue with an in-order scoreboard of issued packets.
module tb_apu_request_queue;
  import accelerator_pkg::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            core_req;
  logic            core_gnt;
  logic [2:0][31:0] core_operands;
  logic [5:0]      core_op;
  logic [14:0]     core_flags;
  logic            dec_req;
  logic            dec_gnt;
  logic [2:0][31:0] dec_operands;
  logic [5:0]      dec_op;
  logic [14:0]     dec_flags;
  logic            dec_rvalid;
  logic [2:0]      count;
  logic [0:0]      outstanding;
  logic            full;
  logic            empty;

  // Second instance with a deeper outstanding limit, used only for the rvalid+pop case.
  logic            reset2;
  logic            core_req2;
  logic            core_gnt2;
  logic            dec_req2;
  logic            dec_gnt2;
  logic [2:0][31:0] dec_operands2;
  logic [5:0]      dec_op2;
  logic [14:0]     dec_flags2;
  logic            dec_rvalid2;
  logic [2:0]      count2;
  logic [1:0]      outstanding2;
  logic            full2;
  logic            empty2;
  logic            flush2;

  int checks = 0;
  int errors = 0;
  apu_req_entry_t sb[$];

  always #5 clk = ~clk;

  apu_request_queue #(.DEPTH(4), .MAX_OUTSTANDING(1)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .core_req(core_req), .core_gnt(core_gnt), .core_operands(core_operands),
    .core_op(core_op), .core_flags(core_flags),
    .dec_req(dec_req), .dec_gnt(dec_gnt), .dec_operands(dec_operands),
    .dec_op(dec_op), .dec_flags(dec_flags), .dec_rvalid(dec_rvalid),
    .count(count), .outstanding(outstanding), .full(full), .empty(empty)
  );

  apu_request_queue #(.DEPTH(4), .MAX_OUTSTANDING(2)) u_dut2 (
    .clk(clk), .reset(reset2), .flush(flush2),
    .core_req(core_req2), .core_gnt(core_gnt2), .core_operands(core_operands),
    .core_op(core_op), .core_flags(core_flags),
    .dec_req(dec_req2), .dec_gnt(dec_gnt2), .dec_operands(dec_operands2),
    .dec_op(dec_op2), .dec_flags(dec_flags2), .dec_rvalid(dec_rvalid2),
    .count(count2), .outstanding(outstanding2), .full(full2), .empty(empty2)
  );

  // Scoreboard: accepted packets are queued, decoder grants must return them in order.
  always @(negedge clk) begin
    apu_req_entry_t e;
    apu_req_entry_t got;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (core_req && core_gnt) begin
        e.operands = core_operands;
        e.op       = core_op;
        e.flags    = core_flags;
        sb.push_back(e);
      end
      if (dec_req && dec_gnt) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL pop_underrun: observed dec_req&dec_gnt expected no pending entry to issue");
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          got.operands = dec_operands;
          got.op       = dec_op;
          got.flags    = dec_flags;
          checks++;
          assert (got === e) else begin
            errors++;
            $error("FAIL pop_data: observed %h expected %h", got, e);
          end
          $display("issue instr=%h op=%h flags=%h", got.operands[0], got.op, got.flags);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_pkt(input logic [31:0] instr, input logic [5:0] op);
    core_operands[0] = instr;
    core_operands[1] = instr ^ 32'hA5A5_5A5A;
    core_operands[2] = {instr[15:0], instr[31:16]};
    core_op          = op;
    core_flags       = instr[14:0] ^ 15'h2A5C;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [5:0] op);
    step();
    drive_pkt(instr, op);
    core_req = 1'b1;
    sample();
    check("push_gnt", core_gnt, 1);
    step();
    core_req = 1'b0;
  endtask

  // Acts as the decoder: grant, then return rvalid one cycle after each issue.
  task automatic drain_all();
    int guard = 0;
    while (sb.size() != 0 && guard < 64) begin
      step();
      dec_gnt = 1'b1;
      dec_rvalid = 1'b0;
      sample();
      if (dec_req) begin
        step();
        dec_gnt = 1'b0;
        dec_rvalid = 1'b1;
      end
      guard++;
    end
    step();
    dec_gnt = 1'b0;
    dec_rvalid = 1'b0;
    check("drain_done", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected $finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; reset2 = 1'b1; flush = 1'b0; flush2 = 1'b0;
    core_req = 1'b0; core_req2 = 1'b0; dec_gnt = 1'b0; dec_gnt2 = 1'b0;
    dec_rvalid = 1'b0; dec_rvalid2 = 1'b0;
    drive_pkt(32'h0, 6'h0);

    // Reset state
    repeat (2) sample();
    check("rst_gnt", core_gnt, 0);
    check("rst_req", dec_req, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_outst", outstanding, 0);
    check("rst_data", dec_operands, 0);
    step();
    reset = 1'b0;

    // Single request
    step();
    drive_pkt(32'h0000_0057, 6'h01);
    core_req = 1'b1;
    sample();
    check("t1_gnt", core_gnt, 1);
`ifdef APU_QUEUE_BYPASS_EN
    check("t1_req_same_cycle", dec_req, 1);
    check("t1_instr_bypass", dec_operands[0], 32'h0000_0057);
`else
    check("t1_req_not_early", dec_req, 0);
`endif
    step();
    core_req = 1'b0;
    sample();
    check("t1_req", dec_req, 1);
    check("t1_count1", count, 1);
    check("t1_op", dec_op, 6'h01);
    check("t1_instr", dec_operands[0], 32'h0000_0057);
    step();
    dec_gnt = 1'b1;
    sample();
    step();
    dec_gnt = 1'b0;
    sample();
    check("t1_count0", count, 0);
    check("t1_outst1", outstanding, 1);
    check("t1_empty", empty, 1);
    check("t1_req_low", dec_req, 0);
    step();
    dec_rvalid = 1'b1;
    step();
    dec_rvalid = 1'b0;
    sample();
    check("t1_outst0", outstanding, 0);

    // Fill to full, fifth request held off, no pass-through on a pop
    for (int i = 0; i < 4; i++) push_one(32'hF000_0000 + 32'(i), 6'(i + 2));
    step();
    drive_pkt(32'hF000_0004, 6'h06);
    core_req = 1'b1;
    sample();
    check("fill_full", full, 1);
    check("fill_gnt", core_gnt, 0);
    check("fill_count", count, 4);
    check("fill_req", dec_req, 1);
    step();
    dec_gnt = 1'b1;
    sample();
    check("fill_no_passthru", core_gnt, 0);
    check("fill_pop_req", dec_req, 1);
    step();
    sample();
    check("fill_gnt_after_pop", core_gnt, 1);
    check("fill_count3", count, 3);
    check("fill_limit_req", dec_req, 0);
    step();
    core_req = 1'b0;
    dec_gnt = 1'b0;
    dec_rvalid = 1'b1;
    sample();
    check("fill_count4", count, 4);
    step();
    dec_rvalid = 1'b0;
    drain_all();

    // Outstanding limit
    push_one(32'hA000_0001, 6'h11);
    push_one(32'hA000_0002, 6'h12);
    step();
    dec_gnt = 1'b1;
    sample();
    check("lim_first_req", dec_req, 1);
    step();
    sample();
    check("lim_held", dec_req, 0);
    check("lim_outst", outstanding, 1);
    step();
    dec_rvalid = 1'b1;
    sample();
    check("lim_held_rvalid_cycle", dec_req, 0);
    step();
    dec_rvalid = 1'b0;
    sample();
    check("lim_second_req", dec_req, 1);
    step();
    dec_gnt = 1'b0;
    dec_rvalid = 1'b1;
    step();
    dec_rvalid = 1'b0;
    sample();
    check("lim_outst0", outstanding, 0);
    check("lim_empty", empty, 1);

    // Push and pop together at count 2
    push_one(32'hB000_0001, 6'h21);
    push_one(32'hB000_0002, 6'h22);
    step();
    drive_pkt(32'hB000_0003, 6'h23);
    core_req = 1'b1;
    dec_gnt = 1'b1;
    sample();
    check("sim_gnt", core_gnt, 1);
    check("sim_req", dec_req, 1);
    step();
    core_req = 1'b0;
    dec_gnt = 1'b0;
    sample();
    check("sim_count2", count, 2);
    check("sim_outst1", outstanding, 1);
    step();
    dec_rvalid = 1'b1;
    step();
    dec_rvalid = 1'b0;
    drain_all();

    // rvalid and pop together (MAX_OUTSTANDING = 2 instance)
    step();
    reset2 = 1'b0;
    drive_pkt(32'hC000_0001, 6'h31);
    core_req2 = 1'b1;
    sample();
    check("d2_gnt1", core_gnt2, 1);
    step();
    core_req2 = 1'b0;
    dec_gnt2 = 1'b1;
    sample();
    check("d2_req1", dec_req2, 1);
    check("d2_instr1", dec_operands2[0], 32'hC000_0001);
    step();
    dec_gnt2 = 1'b0;
    drive_pkt(32'hC000_0002, 6'h32);
    core_req2 = 1'b1;
    sample();
    check("d2_gnt2", core_gnt2, 1);
    step();
    core_req2 = 1'b0;
    sample();
    check("d2_req2", dec_req2, 1);
    check("d2_count1", count2, 1);
    check("d2_instr2", dec_operands2[0], 32'hC000_0002);
    step();
    dec_gnt2 = 1'b1;
    dec_rvalid2 = 1'b1;
    sample();
    check("d2_req_pop", dec_req2, 1);
    step();
    dec_gnt2 = 1'b0;
    dec_rvalid2 = 1'b0;
    sample();
    check("d2_outst_unchanged", outstanding2, 1);
    check("d2_count0", count2, 0);
    reset2 = 1'b1;

    // Flush with one instruction in flight
    push_one(32'hD000_0000, 6'h30);
    step();
    dec_gnt = 1'b1;
    sample();
    step();
    dec_gnt = 1'b0;
    for (int i = 1; i < 4; i++) push_one(32'hD000_0000 + 32'(i), 6'(8'h30 + i));
    step();
    flush = 1'b1;
    drive_pkt(32'hD000_00FF, 6'h3F);
    core_req = 1'b1;
    sample();
    check("fl_gnt", core_gnt, 0);
    check("fl_req", dec_req, 0);
    step();
    flush = 1'b0;
    core_req = 1'b0;
    sample();
    check("fl_count", count, 0);
    check("fl_empty", empty, 1);
    check("fl_outst", outstanding, 1);
    step();
    dec_rvalid = 1'b1;
    step();
    dec_rvalid = 1'b0;
    sample();
    check("fl_outst0", outstanding, 0);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) push_one(32'hE000_0000 + 32'(i), 6'(8'h20 + i));
    step();
    drive_pkt(32'hE000_00AA, 6'h2A);
    core_req = 1'b1;
    dec_gnt = 1'b1;
    sample();
    step();
    #2;
    reset = 1'b1;
    #1;
    check("ar_gnt", core_gnt, 0);
    check("ar_req", dec_req, 0);
    check("ar_count", count, 0);
    check("ar_outst", outstanding, 0);
    check("ar_empty", empty, 1);
    check("ar_full", full, 0);
    check("ar_operands", dec_operands, 0);
    check("ar_op", dec_op, 0);
    check("ar_flags", dec_flags, 0);
    sample();
    step();
    reset = 1'b0;
    core_req = 1'b0;
    dec_gnt = 1'b0;

    // Pointer wrap-around: nine entries through a depth-4 queue
    for (int i = 0; i < 9; i++) begin
      push_one(32'h1234_0100 + 32'(i * 7), 6'(i));
      drain_all();
    end
    sample();
    check("wrap_count", count, 0);
    check("wrap_empty", empty, 1);
    check("wrap_outst", outstanding, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
